// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder built from two half adders and a carry flop
// Adds one operand bit pair per cycle, LSB first, with a start/done handshake.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_next;
  logic [CW-1:0]    cnt;
  logic             carry_q, carry_next;
  logic             s1, c1, sbit, c2;
  logic             accept, finish;

  half_adder ha1 (.a(a_sh[0]), .b(b_sh[0]), .sum(s1),   .carry(c1));
  half_adder ha2 (.a(s1),      .b(carry_q), .sum(sbit), .carry(c2));

  assign carry_next = c1 | c2;

  // New result bits enter at the MSB so the register is LSB-aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_one
      assign sum_next = sbit;
    end else begin : g_many
      assign sum_next = {sbit, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ADD;
        end
      end
      ADD: begin
        if (cnt == LAST) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ADD;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      Sum     <= '0;
      Carry   <= 1'b0;
    end else if (accept) begin
      a_sh    <= A;
      b_sh    <= B;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else if (state == ADD) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      sum_sh  <= sum_next;
      carry_q <= carry_next;
      cnt     <= cnt + CW'(1);
      if (finish) begin
        Sum   <= sum_next;
        Carry <= carry_next;
      end
    end
  end

  assign busy = (state == ADD);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1
// Expected {Carry,Sum} and done cycle are queued at issue and checked by per-instance monitors.

module tb_serial_adder;
  typedef struct {
    logic [8:0] val;
    int         t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start1;
  logic [7:0] A8, B8, Sum8;
  logic       A1, B1, Sum1;
  logic       busy8, done8, Carry8, busy1, done1, Carry1;

  exp_t       q8[$], q1[$];
  logic [8:0] hold8, hold1;
  int         cyc = 0;
  int         passed = 0;
  int         total = 0;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8),
    .busy(busy8), .done(done8), .Sum(Sum8), .Carry(Carry8)
  );

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1),
    .busy(busy1), .done(done1), .Sum(Sum1), .Carry(Carry1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  // WIDTH=8 monitor
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_done_excl8", {31'd0, busy8 & done8}, 32'd0);
      if (done8) begin
        chk("done_expected8", {31'd0, q8.size() != 0}, 32'd1);
        if (q8.size() != 0) begin
          exp_t e;
          e = q8.pop_front();
          chk("result8", {23'd0, Carry8, Sum8}, {23'd0, e.val});
          chk("latency8", cyc, e.t);
          hold8 = e.val;
        end
      end else begin
        chk("hold8", {23'd0, Carry8, Sum8}, {23'd0, hold8});
      end
    end
  end

  // WIDTH=1 monitor
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_done_excl1", {31'd0, busy1 & done1}, 32'd0);
      if (done1) begin
        chk("done_expected1", {31'd0, q1.size() != 0}, 32'd1);
        if (q1.size() != 0) begin
          exp_t e;
          e = q1.pop_front();
          chk("result1", {30'd0, Carry1, Sum1}, {23'd0, e.val});
          chk("latency1", cyc, e.t);
          hold1 = e.val;
        end
      end else begin
        chk("hold1", {30'd0, Carry1, Sum1}, {23'd0, hold1});
      end
    end
  end

  // Called just after a negedge; start is sampled at the following posedge.
  task automatic drive(input bit w1, input logic [7:0] a, input logic [7:0] b, input bit acc);
    exp_t e;
    if (w1) begin
      start1 = 1'b1; A1 = a[0]; B1 = b[0];
      e.val = 9'(a[0]) + 9'(b[0]);
      e.t   = cyc + 1 + 1;
      if (acc) q1.push_back(e);
    end else begin
      start8 = 1'b1; A8 = a; B8 = b;
      e.val = 9'(a) + 9'(b);
      e.t   = cyc + 1 + 8;
      if (acc) q8.push_back(e);
    end
    @(negedge clk);
    if (w1) begin
      start1 = 1'b0; A1 = 1'($urandom); B1 = 1'($urandom);
    end else begin
      start8 = 1'b0; A8 = 8'($urandom); B8 = 8'($urandom);
    end
  endtask

  task automatic drain(input bit w1);
    int n = 0;
    while ((w1 ? q1.size() : q8.size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(w1 ? "drain1" : "drain8", w1 ? q1.size() : q8.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    A8 = '0; B8 = '0; A1 = 1'b0; B1 = 1'b0;
    hold8 = '0; hold1 = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy8", {31'd0, busy8}, 32'd0);
    chk("reset_done8", {31'd0, done8}, 32'd0);
    chk("reset_result8", {23'd0, Carry8, Sum8}, 32'd0);
    chk("reset_result1", {30'd0, Carry1, Sum1}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 3+5: busy for exactly 8 sampled cycles, then done
    drive(1'b0, 8'h03, 8'h05, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("busy_window8", {31'd0, busy8}, 32'd1);
      @(negedge clk);
    end
    chk("busy_low_at_done8", {31'd0, busy8}, 32'd0);
    drain(1'b0);

    drive(1'b0, 8'hFF, 8'h01, 1'b1); drain(1'b0);
    drive(1'b0, 8'hFF, 8'hFF, 1'b1); drain(1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b1); drain(1'b0);

    // WIDTH=1 half-adder truth table
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(i >> 1), 8'(i & 1), 1'b1);
      drain(1'b1);
    end

    // start during ADD is ignored
    drive(1'b0, 8'h10, 8'h20, 1'b1);
    repeat (2) @(negedge clk);
    drive(1'b0, 8'hAA, 8'h55, 1'b0);
    drain(1'b0);
    repeat (12) @(negedge clk);

    // start held high, operands changed in each DONE cycle
    start8 = 1'b1; A8 = 8'h01; B8 = 8'h01;
    q8.push_back('{val: 9'h002, t: cyc + 1 + 8});
    repeat (9) @(negedge clk);
    A8 = 8'h7F; B8 = 8'h01;
    q8.push_back('{val: 9'h080, t: cyc + 1 + 8});
    @(negedge clk);
    start8 = 1'b0;
    drain(1'b0);

    // reset mid-ADD discards the partial result
    drive(1'b0, 8'h80, 8'h80, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_busy8", {31'd0, busy8}, 32'd0);
    chk("midreset_done8", {31'd0, done8}, 32'd0);
    chk("midreset_result8", {23'd0, Carry8, Sum8}, 32'd0);
    q8.delete(); q1.delete();
    hold8 = '0; hold1 = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    drive(1'b0, 8'h80, 8'h80, 1'b1); drain(1'b0);

    // randomized traffic, including back-to-back starts in DONE
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 8'($urandom), 8'($urandom), 1'b1);
      drain(1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 1'b1);
      drain(1'b1);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial multi-bit adder built around the team's half-adder primitive: each cycle two half-adder stages plus a carry flip-flop add one operand bit pair, LSB first. It sits directly downstream of the combinational Half_Adder and consumes its Sum/Carry outputs, extending single-bit addition to WIDTH-bit operands with a start/done handshake. It is intended as the first sequential datapath block in the design and reuses Half_Adder instances unchanged.

## Interface

Parameters:
- WIDTH, default 8: operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock; the block has one clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled on rising edge of clk.
- A  input  WIDTH  operand A; captured on the edge that accepts start.
- B  input  WIDTH  operand B; captured on the edge that accepts start.
- busy  output  1  high while an addition is in progress (state ADD).
- done  output  1  single-cycle pulse marking a new valid result.
- Sum  output  WIDTH  result, low WIDTH bits of A+B; held until the next completion.
- Carry  output  1  carry out of bit WIDTH-1; held with Sum.

## Operation

- States: IDLE, ADD, DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, Sum=0, Carry=0; internal shift registers, carry flop and bit counter are cleared.
- IDLE or DONE with start=1: load A and B into shift registers, clear the carry flop, clear the counter (width ceil(log2(WIDTH+1))), go to ADD.
- IDLE with start=0: stay in IDLE. DONE with start=0: go to IDLE.
- ADD, each cycle:
  - Half_Adder #1 takes a_sh[0] and b_sh[0], giving s1 and c1.
  - Half_Adder #2 takes s1 and the carry flop, giving bit and c2.
  - Next carry = c1 | c2.
  - bit shifts into the MSB of the sum shift register.
  - a_sh and b_sh shift right by one.
  - Counter increments.
- ADD with counter reaching WIDTH-1 on this edge: copy the completed sum shift register into Sum and the next carry into Carry, then go to DONE.
- DONE: done=1 for exactly one cycle. start in DONE is accepted, so back-to-back operations are allowed.
- start while in ADD is ignored; it has no effect on operands or progress.
- A and B are don't-care except on the accepting edge.
- Sum and Carry change only on the completion edge. They are stable during ADD and hold the previous result.
- Arithmetic: {Carry, Sum} = A + B, zero-extended, unsigned, WIDTH+1 bits. There is no carry-in.
- rst asserted at any time, including mid-ADD, immediately returns to IDLE with all outputs at reset values. The partial result is discarded and no done pulse is issued.

## Timing

- Let E0 be the rising edge at which start=1 is sampled in IDLE or DONE.
- busy rises after E0 and stays high through edge E(WIDTH), inclusive of the ADD cycles.
- Bit k (k=0..WIDTH-1) is computed in the cycle between E(k) and E(k+1).
- Sum and Carry update, and done rises, just after E(WIDTH); done falls after E(WIDTH+1).
- Latency from start edge to done high is WIDTH cycles; throughput is one result per WIDTH+1 cycles.
- With start held high continuously, a new operation begins at E(WIDTH+1), in the DONE cycle.
- busy and done are never high in the same cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

- WIDTH=8, A=0x03, B=0x05, one-cycle start → busy high 8 cycles; done high exactly 8 cycles after the start edge; Sum=0x08, Carry=0.
- WIDTH=8, A=0xFF, B=0x01 → Sum=0x00, Carry=1. Then A=0xFF, B=0xFF → Sum=0xFE, Carry=1. Then A=0x00, B=0x00 → Sum=0x00, Carry=0.
- WIDTH=1, apply all four pairs (0,0), (0,1), (1,0), (1,1) → {Carry,Sum} = 00, 01, 01, 10, matching the half-adder truth table; done 1 cycle after each start.
- WIDTH=8: start with A=0x10, B=0x20; pulse start again 3 cycles later with A=0xAA, B=0x55 → second request ignored; Sum=0x30, Carry=0; exactly one done pulse.
- WIDTH=8: start A=0x80, B=0x80, assert rst 4 cycles in → busy, done, Sum and Carry go to 0 immediately with no done pulse. A fresh start A=0x80, B=0x80 then gives Sum=0x00, Carry=1.
- WIDTH=8, start held high, operands changed each DONE cycle (0x01+0x01, then 0x7F+0x01) → done pulses 9 cycles apart; Sum=0x02 then 0x80, Carry=0 both times.
